xocc_mac_engine: RTL and testbench

XOCC_MAC_ENGINE -- requirements
Module: xocc_mac_engine

---
 rtl/xocc_mac_engine.sv | 136 +++++++++++++
 tb/tb_xocc_mac_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xocc_mac_engine.sv
// xocc_mac_engine: serial command engine with a 16-cycle shift-add MAC.
// Ports: cmd FIFO (buffer/empty/rd_en), rsp FIFO (buffer/full/wr_en), busy.
module xocc_mac_engine #(
  parameter int unsigned CMD_WIDTH = 32,
  parameter logic [3:0]  STAT_TAG  = 4'h5
) (
  input  logic                 xocc_clk,
  input  logic                 xocc_rst,
  input  logic [CMD_WIDTH-1:0] xocc_cmd_buffer,
  input  logic                 xocc_cmd_empty,
  output logic                 xocc_cmd_rd_en,
  output logic [31:0]          xocc_rsp_buffer,
  input  logic                 xocc_rsp_full,
  output logic                 xocc_rsp_wr_en,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_CLR    = 4'h1;
  localparam logic [3:0] OP_SETA   = 4'h2;
  localparam logic [3:0] OP_MAC    = 4'h3;
  localparam logic [3:0] OP_RDACC  = 4'h4;
  localparam logic [3:0] OP_RDSTAT = 4'h5;

  state_t      r_state;
  logic [3:0]  r_op;
  logic [15:0] r_opnd;
  logic [15:0] r_a;
  logic [31:0] r_acc;
  logic [31:0] r_prod;
  logic [3:0]  r_bit;
  logic [15:0] r_mac_cnt;
  logic [7:0]  r_err_cnt;
  logic [31:0] r_rsp;

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_addend;
  logic [31:0] w_prod;
  logic        w_unused;

  // Only opcode and operand fields are consumed.
  assign w_unused = ^xocc_cmd_buffer;

  assign w_pop  = (r_state == S_IDLE) & ~xocc_cmd_empty & ~xocc_rst;
  assign w_push = (r_state == S_RESP) & ~xocc_rsp_full & ~xocc_rst;

  assign xocc_cmd_rd_en  = w_pop;
  assign xocc_rsp_wr_en  = w_push;
  assign xocc_rsp_buffer = r_rsp;
  assign busy            = (r_state != S_IDLE);

  // One multiplier bit per cycle; the product is private until the
  // last step, so acc never shows a partial sum.
  assign w_addend = r_opnd[r_bit] ? ({16'h0, r_a} << r_bit) : 32'h0;
  assign w_prod   = r_prod + w_addend;

  always_ff @(posedge xocc_clk) begin
    if (xocc_rst) begin
      r_state   <= S_IDLE;
      r_op      <= 4'h0;
      r_opnd    <= 16'h0;
      r_a       <= 16'h0;
      r_acc     <= 32'h0;
      r_prod    <= 32'h0;
      r_bit     <= 4'h0;
      r_mac_cnt <= 16'h0;
      r_err_cnt <= 8'h0;
      r_rsp     <= 32'h0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op    <= xocc_cmd_buffer[31:28];
            r_opnd  <= xocc_cmd_buffer[15:0];
            r_bit   <= 4'h0;
            r_prod  <= 32'h0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          case (r_op)
            OP_NOP: begin
            end
            OP_CLR: begin
              r_acc     <= 32'h0;
              r_mac_cnt <= 16'h0;
            end
            OP_SETA: begin
              r_a <= r_opnd;
            end
            OP_MAC: begin
              r_prod <= w_prod;
              r_bit  <= r_bit + 4'd1;
              if (r_bit != 4'hF) begin
                r_state <= S_EXEC;
              end else begin
                r_acc     <= r_acc + w_prod;
                r_mac_cnt <= r_mac_cnt + 16'd1;
              end
            end
            OP_RDACC: begin
              r_rsp   <= r_acc;
              r_state <= S_RESP;
            end
            OP_RDSTAT: begin
              r_rsp   <= {STAT_TAG, 4'h0, r_err_cnt, r_mac_cnt};
              r_state <= S_RESP;
            end
            default: begin
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
              r_rsp   <= {16'hDEAD, 12'h000, r_op};
              r_state <= S_RESP;
            end
          endcase
        end
        S_RESP: begin
          if (w_push) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xocc_mac_engine.sv
// tb_xocc_mac_engine: directed bench for xocc_mac_engine.
// Models the command FIFO as a queue and logs pops and responses.
module tb_xocc_mac_engine;

  logic        xocc_clk = 1'b0;
  logic        xocc_rst = 1'b1;
  logic [31:0] xocc_cmd_buffer = '0;
  logic        xocc_cmd_empty = 1'b1;
  logic        xocc_cmd_rd_en;
  logic [31:0] xocc_rsp_buffer;
  logic        xocc_rsp_full = 1'b0;
  logic        xocc_rsp_wr_en;
  logic        busy;

  xocc_mac_engine dut (
    .xocc_clk        (xocc_clk),
    .xocc_rst        (xocc_rst),
    .xocc_cmd_buffer (xocc_cmd_buffer),
    .xocc_cmd_empty  (xocc_cmd_empty),
    .xocc_cmd_rd_en  (xocc_cmd_rd_en),
    .xocc_rsp_buffer (xocc_rsp_buffer),
    .xocc_rsp_full   (xocc_rsp_full),
    .xocc_rsp_wr_en  (xocc_rsp_wr_en),
    .busy            (busy)
  );

  always #5 xocc_clk = ~xocc_clk;

  logic [31:0] cq[$];
  logic [31:0] rsps[$];
  int          pops[$];
  int          wr_cyc[$];
  int          cyc = 0;
  int          ntests = 0;
  int          nfail = 0;
  int          bad_rd = 0;
  int          bad_wr = 0;

  task automatic drive();
    xocc_cmd_empty  = (cq.size() == 0);
    xocc_cmd_buffer = (cq.size() != 0) ? cq[0] : 32'h0;
  endtask

  task automatic clr_log();
    rsps.delete();
    pops.delete();
    wr_cyc.delete();
  endtask

  task automatic tick();
    bit do_pop;
    @(negedge xocc_clk);
    do_pop = 1'b0;
    if (xocc_cmd_rd_en) begin
      pops.push_back(cyc);
      do_pop = 1'b1;
      if (xocc_cmd_empty || xocc_rst) bad_rd++;
    end
    if (xocc_rsp_wr_en) begin
      rsps.push_back(xocc_rsp_buffer);
      wr_cyc.push_back(cyc);
      if (xocc_rsp_full || xocc_rst) bad_wr++;
    end
    @(posedge xocc_clk);
    #1;
    cyc++;
    if (do_pop && cq.size() != 0) void'(cq.pop_front());
    drive();
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((cq.size() != 0 || busy) && n < maxc) begin
      tick();
      n++;
    end
    ntests++;
    if (n >= maxc) begin
      nfail++;
      $display("FAIL run_idle timeout: got %0d cycles, want < %0d", n, maxc);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] rsp_at(input int i);
    return (rsps.size() > i) ? rsps[i] : 32'hxxxxxxxx;
  endfunction

  task automatic test_reset();
    xocc_rst = 1'b1;
    cq.push_back(32'h4000_0000);
    drive();
    repeat (3) begin
      @(negedge xocc_clk);
      ntests++;
      if (xocc_cmd_rd_en !== 1'b0 || xocc_rsp_wr_en !== 1'b0) begin
        nfail++;
        $display("FAIL rst_outputs: got rd=%b wr=%b want 0 0",
                 xocc_cmd_rd_en, xocc_rsp_wr_en);
      end
    end
    @(posedge xocc_clk);
    #1;
    xocc_rst = 1'b0;
    cq.delete();
    drive();
    clr_log();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp", xocc_rsp_buffer, 32'h0);
    repeat (5) tick();
    chk("idle_pops", pops.size(), 0);
    chk("idle_rsps", rsps.size(), 0);
    chk("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic test_rdstat_reset();
    clr_log();
    cq.push_back(32'h5000_0000);
    drive();
    run_idle(20);
    chk("rdstat0_cnt", rsps.size(), 1);
    chk("rdstat0_val", rsp_at(0), 32'h5000_0000);
    if (rsps.size() > 0 && pops.size() > 0)
      chk("rsp_latency", wr_cyc[0] - pops[0], 2);
  endtask

  task automatic test_mac_basic();
    clr_log();
    cq.push_back(32'h2000_0003);
    cq.push_back(32'h3000_0005);
    cq.push_back(32'h3000_0007);
    cq.push_back(32'h4000_0000);
    drive();
    run_idle(100);
    chk("mac_cnt_rsp", rsps.size(), 1);
    chk("mac_val", rsp_at(0), 32'h0000_0024);
    chk("mac_pops", pops.size(), 4);
    if (pops.size() == 4) begin
      chk("seta_gap", pops[1] - pops[0], 2);
      chk("mac_gap", pops[2] - pops[1], 17);
      chk("mac_gap2", pops[3] - pops[2], 17);
    end
  endtask

  task automatic test_wrap();
    clr_log();
    cq.push_back(32'h1000_0000);
    cq.push_back(32'h2000_FFFF);
    cq.push_back(32'h3000_FFFF);
    cq.push_back(32'h3000_FFFF);
    cq.push_back(32'h4000_0000);
    drive();
    run_idle(100);
    chk("wrap_cnt", rsps.size(), 1);
    chk("wrap_val", rsp_at(0), 32'hFFFC_0002);
  endtask

  task automatic test_illegal();
    clr_log();
    cq.push_back(32'h1000_0000);
    cq.push_back(32'h9000_0000);
    cq.push_back(32'h9ABC_0000);
    cq.push_back(32'h9000_1234);
    cq.push_back(32'h5000_0000);
    drive();
    run_idle(60);
    chk("ill_cnt", rsps.size(), 4);
    chk("ill_0", rsp_at(0), 32'hDEAD_0009);
    chk("ill_1", rsp_at(1), 32'hDEAD_0009);
    chk("ill_2", rsp_at(2), 32'hDEAD_0009);
    chk("ill_stat", rsp_at(3), 32'h5003_0000);
  endtask

  task automatic test_err_sat();
    clr_log();
    for (int i = 0; i < 256; i++)
      cq.push_back({4'(6 + (i % 10)), 28'h0});
    cq.push_back(32'h5000_0000);
    drive();
    run_idle(2000);
    chk("sat_cnt", rsps.size(), 257);
    chk("sat_ill", rsp_at(9), 32'hDEAD_000F);
    chk("sat_stat", rsp_at(256), 32'h50FF_0000);
  endtask

  task automatic test_full();
    int stable_bad = 0;
    clr_log();
    cq.push_back(32'h2000_1234);
    cq.push_back(32'h3000_0010);
    drive();
    run_idle(40);
    clr_log();
    xocc_rsp_full = 1'b1;
    cq.push_back(32'h4000_0000);
    cq.push_back(32'h0000_0000);
    drive();
    repeat (2) tick();
    repeat (10) begin
      tick();
      if (xocc_rsp_buffer !== 32'h0001_2340) stable_bad++;
    end
    chk("full_stable", stable_bad, 0);
    chk("full_pops", pops.size(), 1);
    chk("full_rsps", rsps.size(), 0);
    chk("full_busy", {31'h0, busy}, 32'h1);
    xocc_rsp_full = 1'b0;
    tick();
    chk("unfull_cnt", rsps.size(), 1);
    chk("unfull_val", rsp_at(0), 32'h0001_2340);
    if (wr_cyc.size() > 0)
      chk("unfull_when", wr_cyc[0], cyc - 1);
    run_idle(20);
    chk("unfull_once", rsps.size(), 1);
    chk("nop_popped", pops.size(), 2);
  endtask

  task automatic test_reset_mid_mac();
    int n = 0;
    clr_log();
    cq.push_back(32'h1000_0000);
    cq.push_back(32'h2000_0002);
    cq.push_back(32'h3000_0003);
    drive();
    while (pops.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_pop3", pops.size(), 3);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    repeat (7) tick();
    xocc_rst = 1'b1;
    tick();
    xocc_rst = 1'b0;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_no_rsp", rsps.size(), 0);
    cq.push_back(32'h4000_0000);
    drive();
    run_idle(20);
    chk("mid_rdacc_cnt", rsps.size(), 1);
    chk("mid_rdacc", rsp_at(0), 32'h0);
  endtask

  initial begin
    drive();
    test_reset();
    test_rdstat_reset();
    test_mac_basic();
    test_wrap();
    test_illegal();
    test_err_sat();
    test_full();
    test_reset_mid_mac();
    chk("bad_rd_en", bad_rd, 0);
    chk("bad_wr_en", bad_wr, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
